if_stage: RTL and testbench



---
 rtl/if_stage.sv | 160 ++++++++++++++++
 tb/tb_if_stage.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/if_stage.sv
// Instruction-fetch stage: owns the PC, a direct-mapped one-word-per-entry
// instruction cache, and the byte-serial refill path through the shared
// memory controller. Presents pc/inst to IF/ID with a valid/stall handshake.
module if_stage #(
    parameter int          ICACHE_INDEX_BITS = 6,
    parameter int          ICACHE_TAG_BITS   = 10,
    parameter logic [31:0] RESET_PC          = 32'h0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rdy,
    input  logic        stall_i,
    input  logic        jump_or_not,
    input  logic [31:0] jump_addr,
    output logic        mem_req_o,
    output logic [31:0] mem_addr_o,
    input  logic        mem_gnt_i,
    input  logic        mem_valid_i,
    input  logic [7:0]  mem_data_i,
    output logic [31:0] pc_o,
    output logic [31:0] inst_o,
    output logic        inst_valid_o
);

    localparam int ENTRIES = 1 << ICACHE_INDEX_BITS;

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] FETCH = 2'd1;
    localparam logic [1:0] WAIT  = 2'd2;

    logic [1:0]  state;
    logic [31:0] pc;
    logic [2:0]  req_cnt;
    logic [2:0]  rcv_cnt;
    logic [31:0] word_buf;

    logic [ENTRIES-1:0]         cache_valid;
    logic [ICACHE_TAG_BITS-1:0] cache_tag  [ENTRIES];
    logic [31:0]                cache_data [ENTRIES];

    logic [ICACHE_INDEX_BITS-1:0] index;
    logic [ICACHE_TAG_BITS-1:0]   tag;
    logic                         hit;
    logic                         consume;
    logic                         slot_free;
    logic                         last_byte;
    logic [31:0]                  full_word;
    logic [31:0]                  pc_next;

    assign index     = pc[ICACHE_INDEX_BITS+1:2];
    assign tag       = pc[ICACHE_TAG_BITS+ICACHE_INDEX_BITS+1:ICACHE_INDEX_BITS+2];
    assign hit       = cache_valid[index] && (cache_tag[index] == tag);
    assign consume   = inst_valid_o && !stall_i;
    assign slot_free = !inst_valid_o || consume;
    assign pc_next   = pc + 32'd4;

    // The fourth byte completes the word this cycle; bypass it straight
    // into the cache and the output rather than waiting a cycle for word_buf.
    assign last_byte = (state == FETCH) && mem_valid_i && (rcv_cnt == 3'd3);
    assign full_word = {mem_data_i, word_buf[23:0]};

    // Request one byte per cycle while fewer than four have been granted;
    // a redirect kills the request in the same cycle it is seen.
    assign mem_req_o  = rdy && (state == FETCH) && !req_cnt[2] && !jump_or_not;
    assign mem_addr_o = (state == FETCH) ? (pc + {29'd0, req_cnt}) : 32'd0;

    // PC, handshake outputs, refill FSM and cache valid bits.
    // NOTE: sequential state uses non-blocking (<=) so every register samples
    // pre-edge values; blocking here would create order-dependent races.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            pc           <= RESET_PC;
            pc_o         <= 32'd0;
            inst_o       <= 32'd0;
            inst_valid_o <= 1'b0;
            req_cnt      <= 3'd0;
            rcv_cnt      <= 3'd0;
            word_buf     <= 32'd0;
            cache_valid  <= '0;
        end else if (rdy) begin
            // Consumed output drops unless something new loads below.
            if (consume) begin
                inst_valid_o <= 1'b0;
            end

            if (jump_or_not) begin
                pc           <= jump_addr & 32'hFFFF_FFFC;
                inst_valid_o <= 1'b0;
                state        <= IDLE;
                req_cnt      <= 3'd0;
                rcv_cnt      <= 3'd0;
            end else begin
                case (state)
                    IDLE: begin
                        if (hit) begin
                            if (slot_free) begin
                                pc_o         <= pc;
                                inst_o       <= cache_data[index];
                                inst_valid_o <= 1'b1;
                                pc           <= pc_next;
                            end
                        end else begin
                            // Refill starts even while the current output is
                            // stalled; the result parks in WAIT if needed.
                            state   <= FETCH;
                            req_cnt <= 3'd0;
                            rcv_cnt <= 3'd0;
                        end
                    end

                    FETCH: begin
                        if (mem_req_o && mem_gnt_i) begin
                            req_cnt <= req_cnt + 3'd1;
                        end
                        if (mem_valid_i) begin
                            word_buf[8*rcv_cnt[1:0] +: 8] <= mem_data_i;
                            rcv_cnt                       <= rcv_cnt + 3'd1;
                        end
                        if (last_byte) begin
                            cache_valid[index] <= 1'b1;
                            if (slot_free) begin
                                pc_o         <= pc;
                                inst_o       <= full_word;
                                inst_valid_o <= 1'b1;
                                pc           <= pc_next;
                                state        <= IDLE;
                            end else begin
                                state <= WAIT;
                            end
                        end
                    end

                    WAIT: begin
                        if (slot_free) begin
                            pc_o         <= pc;
                            inst_o       <= word_buf;
                            inst_valid_o <= 1'b1;
                            pc           <= pc_next;
                            state        <= IDLE;
                        end
                    end

                    default: state <= IDLE;
                endcase
            end
        end
    end

    // Cache tag/data fill on completion of a refill.
    // NOTE: tag and data arrays are deliberately not reset; the reset valid
    // bits alone make stale contents unobservable and keep the arrays RAM-mappable.
    always_ff @(posedge clk) begin
        if (rdy && !rst && !jump_or_not && last_byte) begin
            cache_tag[index]  <= tag;
            cache_data[index] <= full_word;
        end
    end

endmodule

// File: tb/tb_if_stage.sv
// Directed bench for if_stage: a byte-wide memory responder, a scoreboard of
// expected {pc, inst} pairs popped by a monitor on every consumed output, and
// direct checks for request addresses, timing and reset behaviour.
module tb_if_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        rdy;
    logic        stall_i;
    logic        jump_or_not;
    logic [31:0] jump_addr;
    logic        mem_req_o;
    logic [31:0] mem_addr_o;
    logic        mem_gnt_i;
    logic        mem_valid_i;
    logic [7:0]  mem_data_i;
    logic [31:0] pc_o;
    logic [31:0] inst_o;
    logic        inst_valid_o;

    int checks   = 0;
    int failures = 0;

    logic [7:0]  mem [512];
    logic [63:0] exp_q [$];
    logic [31:0] gnt_log [$];
    int          grant_cnt     = 0;
    int          cyc           = 0;
    int          last_byte_cyc = 0;
    logic        inject_stray  = 1'b0;

    if_stage dut (
        .clk          (clk),
        .rst          (rst),
        .rdy          (rdy),
        .stall_i      (stall_i),
        .jump_or_not  (jump_or_not),
        .jump_addr    (jump_addr),
        .mem_req_o    (mem_req_o),
        .mem_addr_o   (mem_addr_o),
        .mem_gnt_i    (mem_gnt_i),
        .mem_valid_i  (mem_valid_i),
        .mem_data_i   (mem_data_i),
        .pc_o         (pc_o),
        .inst_o       (inst_o),
        .inst_valid_o (inst_valid_o)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got %h required %h", name, act, req);
        end
    endtask

    task automatic timeout(input string name);
        checks++;
        failures++;
        $display("FAIL %s: timed out, awaited event never seen", name);
    endtask

    task automatic set_word(input int a, input logic [31:0] w);
        for (int i = 0; i < 4; i++) mem[a+i] = w[8*i +: 8];
    endtask

    task automatic push_exp(input logic [31:0] p, input logic [31:0] w);
        exp_q.push_back({p, w});
    endtask

    task automatic drive_slot();
        @(posedge clk);
        #2;
    endtask

    // Memory controller model: a byte granted in one cycle returns the next.
    always @(posedge clk) begin
        logic        granted;
        logic [31:0] a;
        granted = !rst && rdy && mem_req_o && mem_gnt_i;
        a       = mem_addr_o;
        if (granted) begin
            gnt_log.push_back(a);
            grant_cnt++;
        end
        #1;
        mem_valid_i = granted || inject_stray;
        mem_data_i  = granted ? mem[a[8:0]] : 8'hFF;
        if (granted) last_byte_cyc = cyc;
    end

    // Scoreboard monitor: every consumed output must match the queue head.
    always @(negedge clk) begin
        logic [63:0] e;
        if (!rst && rdy && inst_valid_o && !stall_i) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL sb_unexpected: got pc %h inst %h, none required", pc_o, inst_o);
            end else begin
                e = exp_q.pop_front();
                check("sb_pc", pc_o, e[63:32]);
                check("sb_inst", inst_o, e[31:0]);
            end
        end
    end

    initial begin
        #200000;
        failures++;
        $display("FAIL watchdog: time limit reached before the run completed");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        int n;
        int base;

        rst = 1'b1; rdy = 1'b1; stall_i = 1'b0; jump_or_not = 1'b0;
        jump_addr = 32'd0; mem_gnt_i = 1'b1; mem_valid_i = 1'b0; mem_data_i = 8'd0;
        for (int i = 0; i < 512; i++) mem[i] = 8'(i * 37 + 11);
        set_word(32'h000, 32'h0010_0513);
        set_word(32'h004, 32'h0020_0593);
        set_word(32'h008, 32'h00B5_0633);
        set_word(32'h00C, 32'hFE00_08E3);
        set_word(32'h010, 32'hDEAD_BEEF);
        set_word(32'h014, 32'h1234_5678);
        set_word(32'h018, 32'hA1B2_C3D4);
        set_word(32'h100, 32'hCAFE_F00D);
        set_word(32'h104, 32'h0BAD_C0DE);

        // Reset state.
        repeat (2) @(negedge clk);
        check("rst_inst_valid", 32'(inst_valid_o), 32'd0);
        check("rst_pc_o", pc_o, 32'd0);
        check("rst_inst_o", inst_o, 32'd0);
        check("rst_mem_req", 32'(mem_req_o), 32'd0);
        check("rst_mem_addr", mem_addr_o, 32'd0);

        // Cold start: four byte reads at 0..3, word presented one cycle later.
        push_exp(32'h0, 32'h0010_0513);
        push_exp(32'h4, 32'h0020_0593);
        push_exp(32'h8, 32'h00B5_0633);
        push_exp(32'hC, 32'hFE00_08E3);
        drive_slot();
        rst = 1'b0;
        n = 0;
        do begin @(negedge clk); n++; end while (!inst_valid_o && n < 100);
        if (!inst_valid_o) timeout("cold_valid");
        check("cold_latency", 32'(cyc - last_byte_cyc), 32'd1);
        check("cold_pc_o", pc_o, 32'h0);
        check("cold_inst_o", inst_o, 32'h0010_0513);
        check("cold_grants", 32'(gnt_log.size()), 32'd4);
        for (int i = 0; i < 4 && i < gnt_log.size(); i++)
            check($sformatf("cold_addr%0d", i), gnt_log[i], 32'(i));

        // Run until 0xC is presented, then jump back to 0x0: four hits.
        n = 0;
        do begin @(negedge clk); n++; end while (!(inst_valid_o && pc_o == 32'hC) && n < 200);
        if (!(inst_valid_o && pc_o == 32'hC)) timeout("reach_0xc");
        push_exp(32'h0, 32'h0010_0513);
        push_exp(32'h4, 32'h0020_0593);
        push_exp(32'h8, 32'h00B5_0633);
        push_exp(32'hC, 32'hFE00_08E3);
        drive_slot();
        jump_or_not = 1'b1;
        jump_addr   = 32'h0;
        @(negedge clk);
        check("loop_jump_req", 32'(mem_req_o), 32'd0);
        drive_slot();
        jump_or_not = 1'b0;
        @(negedge clk);
        check("loop_lookup_req", 32'(mem_req_o), 32'd0);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check($sformatf("hit%0d_valid", k), 32'(inst_valid_o), 32'd1);
            check($sformatf("hit%0d_pc", k), pc_o, 32'(4 * k));
            check($sformatf("hit%0d_req", k), 32'(mem_req_o), 32'd0);
        end

        // Grant dropped for two cycles after the first byte of 0x10.
        gnt_log.delete();
        base = grant_cnt;
        push_exp(32'h10, 32'hDEAD_BEEF);
        push_exp(32'h14, 32'h1234_5678);
        n = 0;
        do begin @(negedge clk); n++; end while (!(mem_req_o && mem_addr_o == 32'h10) && n < 50);
        if (!(mem_req_o && mem_addr_o == 32'h10)) timeout("fetch_0x10");
        drive_slot();
        mem_gnt_i = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check($sformatf("gntloss_req%0d", k), 32'(mem_req_o), 32'd1);
            check($sformatf("gntloss_addr%0d", k), mem_addr_o, 32'h11);
            drive_slot();
            if (k == 1) mem_gnt_i = 1'b1;
            if (k == 2) stall_i = 1'b1;
        end

        // 0x10 presented under stall; 0x14 refills and parks in WAIT.
        n = 0;
        do begin @(negedge clk); n++; end while (!inst_valid_o && n < 50);
        if (!inst_valid_o) timeout("valid_0x10");
        check("gntloss_pc_o", pc_o, 32'h10);
        check("gntloss_grants", 32'(grant_cnt - base), 32'd4);
        for (int i = 0; i < 4 && i < gnt_log.size(); i++)
            check($sformatf("gntloss_log%0d", i), gnt_log[i], 32'(32'h10 + i));
        n = 0;
        do begin @(negedge clk); n++; end while (grant_cnt - base < 8 && n < 50);
        if (grant_cnt - base < 8) timeout("fetch_0x14");
        repeat (2) begin
            @(negedge clk);
            check("wait_valid", 32'(inst_valid_o), 32'd1);
            check("wait_pc_o", pc_o, 32'h10);
            check("wait_inst_o", inst_o, 32'hDEAD_BEEF);
            check("wait_req", 32'(mem_req_o), 32'd0);
        end
        check("wait_no_extra_grant", 32'(grant_cnt - base), 32'd8);
        drive_slot();
        stall_i = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("wait_release_valid", 32'(inst_valid_o), 32'd1);
        check("wait_release_pc", pc_o, 32'h14);

        // Jump to 0x103 after two bytes of 0x18 arrived, plus a stray byte.
        n = 0;
        do begin @(negedge clk); n++; end while (!(mem_req_o && mem_addr_o == 32'h1A) && n < 50);
        if (!(mem_req_o && mem_addr_o == 32'h1A)) timeout("fetch_0x1a");
        drive_slot();
        jump_or_not  = 1'b1;
        jump_addr    = 32'h103;
        inject_stray = 1'b1;
        @(negedge clk);
        check("jump_req_forced", 32'(mem_req_o), 32'd0);
        drive_slot();
        jump_or_not  = 1'b0;
        inject_stray = 1'b0;
        gnt_log.delete();
        push_exp(32'h100, 32'hCAFE_F00D);
        @(negedge clk);
        check("jump_valid_clear", 32'(inst_valid_o), 32'd0);
        n = 0;
        do begin @(negedge clk); n++; end while (!inst_valid_o && n < 50);
        if (!inst_valid_o) timeout("valid_0x100");
        check("jump_first_addr", (gnt_log.size() > 0) ? gnt_log[0] : 32'hFFFF_FFFF, 32'h100);

        // Reset in the middle of the 0x104 refill.
        gnt_log.delete();
        n = 0;
        do begin @(negedge clk); n++; end while (gnt_log.size() < 2 && n < 50);
        if (gnt_log.size() < 2) timeout("fetch_0x104");
        drive_slot();
        rst = 1'b1;
        @(negedge clk);
        check("midrst_valid", 32'(inst_valid_o), 32'd0);
        check("midrst_pc_o", pc_o, 32'd0);
        check("midrst_inst_o", inst_o, 32'd0);
        check("midrst_req", 32'(mem_req_o), 32'd0);
        check("midrst_addr", mem_addr_o, 32'd0);
        drive_slot();
        drive_slot();
        rst       = 1'b0;
        mem_gnt_i = 1'b0;
        base      = grant_cnt;
        push_exp(32'h0, 32'h0010_0513);
        push_exp(32'h4, 32'h0020_0593);
        push_exp(32'h8, 32'h00B5_0633);
        n = 0;
        do begin @(negedge clk); n++; end while (!mem_req_o && n < 20);
        if (!mem_req_o) timeout("refetch_req");
        check("refetch_addr", mem_addr_o, 32'h0);

        // rdy low freezes the stage and suppresses requests.
        drive_slot();
        rdy = 1'b0;
        repeat (2) begin
            @(negedge clk);
            check("rdy_low_req", 32'(mem_req_o), 32'd0);
            check("rdy_low_valid", 32'(inst_valid_o), 32'd0);
            drive_slot();
        end
        rdy       = 1'b1;
        mem_gnt_i = 1'b1;
        @(negedge clk);
        check("rdy_resume_addr", mem_addr_o, 32'h0);

        // All three words must come from memory: the cache was invalidated.
        n = 0;
        do begin @(negedge clk); n++; end while (exp_q.size() != 0 && n < 200);
        check("sb_drained", 32'(exp_q.size()), 32'd0);
        check("refetch_grants", 32'(grant_cnt - base), 32'd12);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
